// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default payload widths and per-stage control
// word layouts with their NOP encodings.
package pipe_pkg;

   localparam int PIPE_DATA_W = 160;
   localparam int PIPE_CTRL_W = 16;
   localparam int ALU_OP_W    = 4;

   // Bit offsets of the ID/EX control fields within the packed word.
   localparam int ALU_OP_LSB    = 0;
   localparam int ALU_SRC2_BIT  = 4;
   localparam int ALU_SRC1_BIT  = 5;
   localparam int MEM_TO_REG_BIT = 6;
   localparam int MEM_WRITE_BIT = 7;
   localparam int MEM_READ_BIT  = 8;
   localparam int REG_DST_BIT   = 9;
   localparam int REG_WRITE_BIT = 10;
   localparam int BRANCH_BIT    = 11;
   localparam int PC_SRC_BIT    = 12;

   typedef struct packed {
      logic [2:0]          rsvd;
      logic                pc_src;
      logic                branch;
      logic                reg_write;
      logic                reg_dst;
      logic                mem_read;
      logic                mem_write;
      logic                mem_to_reg;
      logic                alu_src1;
      logic                alu_src2;
      logic [ALU_OP_W-1:0] alu_op;
   } id_ex_ctrl_t;

   typedef struct packed {
      logic [9:0] rsvd;
      logic       pc_src;
      logic       branch;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
   } ex_mem_ctrl_t;

   typedef struct packed {
      logic [13:0] rsvd;
      logic        reg_write;
      logic        mem_to_reg;
   } mem_wb_ctrl_t;

   // A bubble must never write registers or memory, nor redirect the PC.
   localparam id_ex_ctrl_t  ID_EX_NOP  = '0;
   localparam ex_mem_ctrl_t EX_MEM_NOP = '0;
   localparam mem_wb_ctrl_t MEM_WB_NOP = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by
// synchronous reset only.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional two-entry
// skid buffer, flush with NOP control-word bubbles, and a stall-cycle counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = PIPE_DATA_W,
   parameter int                CTRL_W   = PIPE_CTRL_W,
   parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
   parameter bit                SKID     = 1'b1,
   parameter int                STAT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [STAT_W-1:0] stall_cnt
);

   logic              main_vld_q, main_vld_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic              accept;
   logic              consume;

   assign accept  = in_valid && in_ready && !flush;
   assign consume = main_vld_q && out_ready;

   generate
      if (SKID) begin : g_skid
         logic              skid_vld_q, skid_vld_d;
         logic [DATA_W-1:0] skid_data_q, skid_data_d;
         logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
         logic              in_ready_q;

         always_comb begin
            main_vld_d  = main_vld_q;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
            skid_vld_d  = skid_vld_q;
            skid_data_d = skid_data_q;
            skid_ctrl_d = skid_ctrl_q;
            if (!main_vld_q || consume) begin
               if (skid_vld_q) begin
                  main_vld_d  = 1'b1;
                  main_data_d = skid_data_q;
                  main_ctrl_d = skid_ctrl_q;
                  skid_vld_d  = 1'b0;
               end else if (accept) begin
                  main_vld_d  = 1'b1;
                  main_data_d = in_data;
                  main_ctrl_d = in_ctrl;
               end else begin
                  main_vld_d  = 1'b0;
               end
            end else if (accept) begin
               skid_vld_d  = 1'b1;
               skid_data_d = in_data;
               skid_ctrl_d = in_ctrl;
            end
            if (flush) begin
               main_vld_d = 1'b0;
               skid_vld_d = 1'b0;
            end
         end

         // in_ready is a flop so upstream never sees a path from out_ready.
         always_ff @(posedge clk) begin
            if (reset) begin
               skid_vld_q <= 1'b0;
               in_ready_q <= 1'b1;
            end else begin
               skid_vld_q <= skid_vld_d;
               in_ready_q <= !skid_vld_d;
            end
         end

         always_ff @(posedge clk) begin
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
         end

         assign in_ready = in_ready_q;
      end else begin : g_single
         assign in_ready = !main_vld_q || out_ready;

         always_comb begin
            main_vld_d  = main_vld_q;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
            if (accept) begin
               main_vld_d  = 1'b1;
               main_data_d = in_data;
               main_ctrl_d = in_ctrl;
            end else if (consume) begin
               main_vld_d  = 1'b0;
            end
            if (flush) begin
               main_vld_d = 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         main_vld_q  <= 1'b0;
         main_data_q <= '0;
         main_ctrl_q <= NOP_CTRL;
      end else begin
         main_vld_q  <= main_vld_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
      end
   end

   assign out_valid = main_vld_q;
   assign out_data  = main_data_q;
   // Bubbles carry the NOP word so downstream may decode without checking valid.
   assign out_ctrl  = main_vld_q ? main_ctrl_q : NOP_CTRL;

   sat_counter #(
      .W(STAT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (main_vld_q && !out_ready),
      .count(stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid, single-entry and 4-bit-counter
// instances driven through hand-computed sequences.
module tb_pipe_stage_skid;

   localparam logic [15:0] NOP = 16'h0F00;

   logic clk = 1'b0;
   logic reset;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   logic        m_in_valid, m_in_ready, m_flush, m_out_valid, m_out_ready;
   logic [31:0] m_in_data, m_out_data;
   logic [15:0] m_in_ctrl, m_out_ctrl, m_stall;

   logic        z_in_valid, z_in_ready, z_flush, z_out_valid, z_out_ready;
   logic [31:0] z_in_data, z_out_data;
   logic [15:0] z_in_ctrl, z_out_ctrl, z_stall;

   logic        s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
   logic [31:0] s_in_data, s_out_data;
   logic [15:0] s_in_ctrl, s_out_ctrl;
   logic [3:0]  s_stall;

   pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .NOP_CTRL(NOP), .SKID(1'b1), .STAT_W(16)) u_dut (
      .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
      .in_data(m_in_data), .in_ctrl(m_in_ctrl), .flush(m_flush),
      .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data),
      .out_ctrl(m_out_ctrl), .stall_cnt(m_stall));

   pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .NOP_CTRL(NOP), .SKID(1'b0), .STAT_W(16)) u_dut0 (
      .clk(clk), .reset(reset), .in_valid(z_in_valid), .in_ready(z_in_ready),
      .in_data(z_in_data), .in_ctrl(z_in_ctrl), .flush(z_flush),
      .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
      .out_ctrl(z_out_ctrl), .stall_cnt(z_stall));

   pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .NOP_CTRL(NOP), .SKID(1'b1), .STAT_W(4)) u_sat (
      .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .in_ctrl(s_in_ctrl), .flush(s_flush),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .out_ctrl(s_out_ctrl), .stall_cnt(s_stall));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      m_in_valid = 1'b0; m_in_data = '0; m_in_ctrl = '0; m_flush = 1'b0; m_out_ready = 1'b0;
      z_in_valid = 1'b0; z_in_data = '0; z_in_ctrl = '0; z_flush = 1'b0; z_out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_in_ctrl = '0; s_flush = 1'b0; s_out_ready = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_out_valid", 64'(m_out_valid), 64'd0);
      chk("rst_in_ready",  64'(m_in_ready),  64'd1);
      chk("rst_out_data",  64'(m_out_data),  64'd0);
      chk("rst_out_ctrl",  64'(m_out_ctrl),  64'(NOP));
      chk("rst_stall",     64'(m_stall),     64'd0);
      reset = 1'b0;

      // Streaming with out_ready held high
      m_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         m_in_valid = 1'b1;
         m_in_data  = 32'h100 + 32'(i);
         m_in_ctrl  = 16'h00A5;
         tick();
         chk("stream_valid", 64'(m_out_valid), 64'd1);
         chk("stream_data",  64'(m_out_data),  64'(32'h100 + 32'(i)));
         chk("stream_ctrl",  64'(m_out_ctrl),  64'h00A5);
         chk("stream_ready", 64'(m_in_ready),  64'd1);
      end
      m_in_valid = 1'b0;
      tick();
      chk("stream_end_valid", 64'(m_out_valid), 64'd0);
      chk("stream_end_ctrl",  64'(m_out_ctrl),  64'(NOP));
      chk("stream_end_hold",  64'(m_out_data),  64'h107);
      chk("stream_end_stall", 64'(m_stall),     64'd0);

      // Back-pressure: A in main, B in skid, C held upstream
      m_out_ready = 1'b0;
      m_in_valid = 1'b1; m_in_data = 32'hAAAA_0001; m_in_ctrl = 16'h0011;
      tick();
      m_in_data = 32'hBBBB_0002; m_in_ctrl = 16'h0022;
      tick();
      chk("bp_ready_low", 64'(m_in_ready), 64'd0);
      m_in_data = 32'hCCCC_0003; m_in_ctrl = 16'h0033;
      tick();
      tick();
      chk("bp_valid", 64'(m_out_valid), 64'd1);
      chk("bp_data_a", 64'(m_out_data), 64'hAAAA_0001);
      chk("bp_ctrl_a", 64'(m_out_ctrl), 64'h0011);
      chk("bp_in_ready", 64'(m_in_ready), 64'd0);
      chk("bp_stall3", 64'(m_stall), 64'd3);
      m_out_ready = 1'b1;
      tick();
      chk("bp_data_b", 64'(m_out_data), 64'hBBBB_0002);
      chk("bp_ctrl_b", 64'(m_out_ctrl), 64'h0022);
      chk("bp_ready_back", 64'(m_in_ready), 64'd1);
      tick();
      chk("bp_valid_c", 64'(m_out_valid), 64'd1);
      chk("bp_data_c", 64'(m_out_data), 64'hCCCC_0003);
      m_in_valid = 1'b0;
      tick();
      chk("bp_drained", 64'(m_out_valid), 64'd0);
      chk("bp_stall_keep", 64'(m_stall), 64'd3);

      // Flush with a full skid and an entry offered in the same cycle
      m_out_ready = 1'b0;
      m_in_valid = 1'b1; m_in_data = 32'hDDDD_0004; m_in_ctrl = 16'h0044;
      tick();
      m_in_data = 32'hEEEE_0005; m_in_ctrl = 16'h0055;
      tick();
      chk("fl_skid_full", 64'(m_in_ready), 64'd0);
      chk("fl_stall4", 64'(m_stall), 64'd4);
      m_flush = 1'b1; m_in_data = 32'hFFFF_0006; m_in_ctrl = 16'h0066;
      tick();
      m_flush = 1'b0; m_in_valid = 1'b0;
      chk("fl_valid", 64'(m_out_valid), 64'd0);
      chk("fl_ctrl_nop", 64'(m_out_ctrl), 64'(NOP));
      chk("fl_data_hold", 64'(m_out_data), 64'hDDDD_0004);
      chk("fl_in_ready", 64'(m_in_ready), 64'd1);
      chk("fl_stall_kept", 64'(m_stall), 64'd5);
      m_in_valid = 1'b1; m_in_data = 32'h1234_0007; m_in_ctrl = 16'h0077; m_out_ready = 1'b1;
      tick();
      chk("fl_next_valid", 64'(m_out_valid), 64'd1);
      chk("fl_next_data", 64'(m_out_data), 64'h1234_0007);
      chk("fl_next_ctrl", 64'(m_out_ctrl), 64'h0077);
      m_in_valid = 1'b0;
      tick();
      chk("fl_no_ghost", 64'(m_out_valid), 64'd0);

      // Flush and consume in the same cycle
      m_out_ready = 1'b0;
      m_in_valid = 1'b1; m_in_data = 32'h4444_0008; m_in_ctrl = 16'h0088;
      tick();
      m_in_data = 32'h5555_0009; m_in_ctrl = 16'h0099;
      tick();
      chk("fc_stall6", 64'(m_stall), 64'd6);
      m_in_valid = 1'b0; m_flush = 1'b1; m_out_ready = 1'b1;
      #1;
      chk("fc_cur_valid", 64'(m_out_valid), 64'd1);
      chk("fc_cur_data", 64'(m_out_data), 64'h4444_0008);
      tick();
      m_flush = 1'b0;
      chk("fc_after1", 64'(m_out_valid), 64'd0);
      tick();
      chk("fc_after2", 64'(m_out_valid), 64'd0);
      chk("fc_stall", 64'(m_stall), 64'd6);

      // Single-entry variant with out_ready toggling every cycle
      z_in_valid = 1'b1; z_in_ctrl = 16'h0003;
      for (int i = 0; i < 8; i++) begin
         z_out_ready = (i % 2 == 0);
         z_in_data   = 32'h5000 + 32'((i + 1) / 2);
         #1;
         chk("s0_in_ready", 64'(z_in_ready), 64'(i % 2 == 0));
         if (i > 0 && (i % 2 == 0)) begin
            chk("s0_consumed", 64'(z_out_data), 64'(32'h5000 + 32'(i / 2 - 1)));
         end
         tick();
         chk("s0_valid", 64'(z_out_valid), 64'd1);
         chk("s0_data",  64'(z_out_data),  64'(32'h5000 + 32'(i / 2)));
      end
      z_in_valid = 1'b0;

      // Saturation of a 4-bit stall counter, then reset mid-stall
      s_out_ready = 1'b0;
      s_in_valid = 1'b1; s_in_data = 32'h0000_0007; s_in_ctrl = 16'h0001;
      tick();
      s_in_valid = 1'b0;
      for (int i = 0; i < 14; i++) tick();
      chk("sat_14", 64'(s_stall), 64'd14);
      tick();
      chk("sat_15", 64'(s_stall), 64'd15);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_hold", 64'(s_stall), 64'd15);
      chk("sat_valid", 64'(s_out_valid), 64'd1);
      s_in_valid = 1'b1; s_in_data = 32'h0000_0008;
      reset = 1'b1;
      tick();
      chk("mr_valid", 64'(s_out_valid), 64'd0);
      chk("mr_data",  64'(s_out_data),  64'd0);
      chk("mr_ctrl",  64'(s_out_ctrl),  64'(NOP));
      chk("mr_stall", 64'(s_stall),     64'd0);
      chk("mr_ready", 64'(s_in_ready),  64'd1);
      reset = 1'b0; s_in_valid = 1'b0;
      tick();
      chk("mr_no_pulse", 64'(s_out_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
